stack_controller: RTL
=====================

# stack_controller

Frame stack serving the Fibonacci datapath controller's `pushSig`/`popSig` requests and returning `readySig` when each operation completes. Each frame holds one `n` and one `flag` byte. The block owns the storage, stack pointer and full/empty bookkeeping. It also seeds the stack with the initial argument when a computation starts.

## Interface
- `DEPTH`, 16: frame capacity; power of two, ≥2.
- `W`, 8: width of `n` and `flag` fields.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse; clears the stack and pushes the seed frame.
- `n_init` input W: seed `n`; the seed flag is fixed at 1.
- `pushSig` input 1: push request; held by the requester until `readySig`.
- `popSig` input 1: pop request; held by the requester until `readySig`.
- `n_in`, `flag_in` input W each: frame to push; sampled on request acceptance.
- `readySig` output 1: one-cycle completion pulse.
- `n_out`, `flag_out` output W each: last popped frame, registered.
- `empty`, `full` output 1 each: registered pointer status.
- `overflow`, `underflow` output 1 each: sticky error flags.

## Operation
- States: `IDLE`, `SEED`, `PUSH`, `POP`, `ACK`.
- Requests are sampled only in `IDLE`. Priority: `start` > `pushSig` > `popSig`.
- `IDLE`→`SEED` on `start`: `sp`←0, write `{n_init, 1}` to `mem[0]`, `sp`←1, then →`ACK`.
- `IDLE`→`PUSH`: latch `{n_in, flag_in}`, write `mem[sp]`, `sp`←`sp+1`, then →`ACK`.
- `IDLE`→`POP`: `sp`←`sp-1`, `{n_out, flag_out}`←`mem[sp-1]`, then →`ACK`.
- `ACK`: `readySig`=1 for exactly one cycle, then →`IDLE`.
  - No release wait; the requester changes state on the same edge.
- If push and pop are both asserted: push is served first. Pop stays pending and is served on the next `IDLE` sample if still held.
- `sp` is $clog2(DEPTH)+1 bits wide.
  - `empty` = (`sp`==0).
  - `full` = (`sp`==DEPTH).
  - Both are updated with `sp`.
- `n_out`/`flag_out` hold their value until the next successful pop.

## Timing
- Reset values: `readySig`, `n_out`, `flag_out`, `full`, `overflow`, `underflow` = 0; `empty` = 1; `sp` = 0; state `IDLE`. Memory contents are not cleared.
- Latency: request high in `IDLE` at edge k → `readySig` high during cycle k+2. Pop data is valid in the same cycle as `readySig`.
- Maximum throughput: one operation per 3 cycles.
- `rst` during `SEED`/`PUSH`/`POP`/`ACK`: the operation is aborted and no `readySig` is issued. A write already committed on the prior edge stays in memory, but `sp` returns to 0.
- `start` outside `IDLE` is ignored. It is not queued.

## Configuration
- `STACK_GUARD_EN` defined:
  - Push when `full`: data dropped, `sp` unchanged, `overflow`←1, `readySig` still pulses.
  - Pop when `empty`: `n_out`/`flag_out`←0, `sp` unchanged, `underflow`←1, `readySig` still pulses.
  - Sticky flags clear only on `rst` or `start`.
- `STACK_GUARD_EN` undefined:
  - `sp` wraps modulo 2·DEPTH with no check, and memory is indexed with `sp` mod DEPTH.
  - `overflow`/`underflow` tied to 0.
  - `empty`/`full` still reported.

## Structure
- The shared package `fib_pkg` holds:
  - the state enum (`IDLE`, `SEED`, `PUSH`, `POP`, `ACK`),
  - the default frame width `W`,
  - the constant `SEED_FLAG`=1.
  - `fib_pkg` is shared with the datapath controller.
- One sub-module, `stack_mem`: a DEPTH×2W register file.
  - Synchronous write port.
  - Combinational read port, registered in the parent.

## Test plan
- Reset → `readySig`=0, `empty`=1, `full`=0, `n_out`=0. Then `start` with `n_init`=5 → `readySig` at +2 cycles, `sp`=1; a following pop returns `n_out`=5, `flag_out`=1, `empty`=1.
- Push {3,1}, {2,2}, {7,0}, then three pops → frames returned {7,0}, {2,2}, {3,1}. Each `readySig` arrives exactly 2 cycles after the request and lasts 1 cycle.
- DEPTH=4: fill with 4 pushes (`full`=1), then a 5th push {9,9}.
  - Guard on: `overflow`=1, next pop returns the 4th frame.
  - Guard off: `sp` wraps and the next pop returns {9,9}.
- Pop on empty:
  - Guard on: `underflow`=1, outputs 0, `readySig` pulses.
  - After `start`: `underflow`=0.
- `pushSig` and `popSig` both held: the push completes first, the pop completes 3 cycles later. Also assert `rst` during `POP` → no `readySig`, `sp`=0, `empty`=1.

Source files
------------

// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Types and constants shared by the Fibonacci datapath controller and its frame
// stack (stack_controller).
//   state_t   : handshake FSM states (IDLE, SEED, PUSH, POP, ACK)
//   W         : default width of the frame fields n and flag
//   SEED_FLAG : flag value stored with the seed frame at start
// -----------------------------------------------------------------------------
package fib_pkg;

    localparam int W         = 8;
    localparam int SEED_FLAG = 1;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        PUSH,
        POP,
        ACK
    } state_t;

endpackage

// File: rtl/stack_mem.sv
// -----------------------------------------------------------------------------
// stack_mem
// DEPTH x WIDTH register file holding the stack frames.
// Ports:
//   clk   : write clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data ({n, flag})
//   raddr : read address
//   rdata : combinational read data (registered by the parent)
// -----------------------------------------------------------------------------
module stack_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset; the stack pointer alone defines
    // which entries are meaningful, and leaving the array unreset keeps it a
    // plain register file / RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_controller.sv
// -----------------------------------------------------------------------------
// stack_controller
// Frame stack for the Fibonacci datapath controller. Serves held push/pop
// requests with a one-cycle readySig completion pulse and seeds the stack with
// {n_init, SEED_FLAG} on start. Each operation takes IDLE -> op -> ACK.
//
// Optional feature macro: STACK_GUARD_EN
//   defined   : push on full / pop on empty are refused, raising the sticky
//               overflow / underflow flags (cleared by rst or start).
//   undefined : sp wraps modulo 2*DEPTH, overflow/underflow stay 0.
//
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   start, n_init     : clear stack and push seed frame {n_init, SEED_FLAG}
//   pushSig, popSig   : held requests, served in IDLE (start > push > pop)
//   n_in, flag_in     : frame to push, sampled on acceptance
//   readySig          : one-cycle completion pulse
//   n_out, flag_out   : last popped frame, registered
//   empty, full       : registered pointer status
//   overflow,underflow: sticky error flags (guard build only)
// -----------------------------------------------------------------------------
module stack_controller #(
    parameter int DEPTH = 16,
    parameter int W     = fib_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] n_init,
    input  logic         pushSig,
    input  logic         popSig,
    input  logic [W-1:0] n_in,
    input  logic [W-1:0] flag_in,
    output logic         readySig,
    output logic [W-1:0] n_out,
    output logic [W-1:0] flag_out,
    output logic         empty,
    output logic         full,
    output logic         overflow,
    output logic         underflow
);

    import fib_pkg::*;

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    state_t           state;
    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   sp_nxt;
    logic [W-1:0]     n_lat;
    logic [W-1:0]     f_lat;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [2*W-1:0]   rdata;
    logic             push_blocked;
    logic             pop_blocked;

`ifdef STACK_GUARD_EN
    assign push_blocked = (sp == SP_FULL);
    assign pop_blocked  = (sp == '0);
`else
    assign push_blocked = 1'b0;
    assign pop_blocked  = 1'b0;
`endif

    // The write of an aborted operation is suppressed on the reset edge.
    assign we    = !rst && ((state == SEED) || ((state == PUSH) && !push_blocked));
    assign waddr = (state == SEED) ? '0 : sp[AW-1:0];
    // Top-of-stack entry; the AW-bit subtraction gives the mod-DEPTH index.
    assign raddr = sp[AW-1:0] - AW'(1);

    stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (2 * W)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata ({n_lat, f_lat}),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Next stack pointer; empty/full are registered from it so they change
    // on the same edge as sp.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sp_nxt = sp;
        case (state)
            IDLE:    if (start)         sp_nxt = '0;
            SEED:                       sp_nxt = SPW'(1);
            PUSH:    if (!push_blocked) sp_nxt = sp + SPW'(1);
            POP:     if (!pop_blocked)  sp_nxt = sp - SPW'(1);
            default:                    sp_nxt = sp;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sp        <= '0;
            readySig  <= 1'b0;
            n_out     <= '0;
            flag_out  <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp    <= sp_nxt;
            empty <= (sp_nxt == '0);
            full  <= (sp_nxt == SP_FULL);
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat     <= n_init;
                        f_lat     <= W'(SEED_FLAG);
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        state     <= SEED;
                    end else if (pushSig) begin
                        n_lat <= n_in;
                        f_lat <= flag_in;
                        state <= PUSH;
                    end else if (popSig) begin
                        state <= POP;
                    end
                end
                SEED: begin
                    readySig <= 1'b1;
                    state    <= ACK;
                end
                PUSH: begin
`ifdef STACK_GUARD_EN
                    if (push_blocked) overflow <= 1'b1;
`endif
                    readySig <= 1'b1;
                    state    <= ACK;
                end
                POP: begin
                    if (pop_blocked) begin
                        n_out    <= '0;
                        flag_out <= '0;
`ifdef STACK_GUARD_EN
                        underflow <= 1'b1;
`endif
                    end else begin
                        {n_out, flag_out} <= rdata;
                    end
                    readySig <= 1'b1;
                    state    <= ACK;
                end
                ACK: begin
                    // Requester drops its request on this same edge.
                    readySig <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
